user_wr_arbiter: RTL and testbench

USER_WR_ARBITER -- requirements
Module: user_wr_arbiter

---
 rtl/user_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_user_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_wr_arbiter.sv
// Round-robin write arbiter: merges NUM_REQ beat streams into one user FIFO write port,
// granting one requester per burst and releasing on last beat, burst cap or idle requester.
module user_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      user_wrreq,
   output logic [DATA_W-1:0]         user_data,
   input  logic                      user_flag_0,
   input  logic                      user_flag_1,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      ovf_err
);
   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

   state_t            state_reg, state_next;
   logic [2:0]        grant_reg, grant_next;
   logic [2:0]        last_grant_reg, last_grant_next;
   logic [7:0]        beat_cnt_reg, beat_cnt_next;
   logic              wrreq_reg, wrreq_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              ovf_reg;

   logic [3:0]         cand_sum   [NUM_REQ];
   logic [2:0]         cand_idx   [NUM_REQ];
   logic [NUM_REQ-1:0] cand_valid;
   logic [DATA_W-1:0]  beat_data  [NUM_REQ];

   logic              pick_found;
   logic [2:0]        pick_idx;
   logic              valid_g, last_g;
   logic [DATA_W-1:0] data_g;

   // Candidate gi of the search is (last_grant + 1 + gi) mod NUM_REQ.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign cand_sum[gi]   = {1'b0, last_grant_reg} + 4'(gi + 1);
         assign cand_idx[gi]   = (cand_sum[gi] >= 4'(NUM_REQ)) ?
                                 3'(cand_sum[gi] - 4'(NUM_REQ)) : cand_sum[gi][2:0];
         assign cand_valid[gi] = |(req_valid & (NUM_REQ'(1) << cand_idx[gi]));
         assign beat_data[gi]  = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Walk from the far end so the nearest candidate after last_grant wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 3'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx[k];
         end
      end
   end

   always_comb begin
      valid_g = 1'b0;
      last_g  = 1'b0;
      data_g  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_reg == 3'(i)) begin
            valid_g = req_valid[i];
            last_g  = req_last[i];
            data_g  = beat_data[i];
         end
      end
   end

   // Ready is also masked by reset so no requester sees a beat taken that the reset discards.
   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      beat_cnt_next   = beat_cnt_reg;
      wrreq_next      = 1'b0;
      data_next       = data_reg;
      req_ready       = '0;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               grant_next      = pick_idx;
               last_grant_next = pick_idx;
               beat_cnt_next   = 8'd0;
               state_next      = XFER;
            end
         end
         XFER: begin
            if (reset_reset_n && !user_flag_1) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (grant_reg == 3'(i)) req_ready[i] = 1'b1;
               end
               if (valid_g) begin
                  wrreq_next    = 1'b1;
                  data_next     = data_g;
                  beat_cnt_next = beat_cnt_reg + 8'd1;
                  if (last_g || (beat_cnt_reg + 8'd1 == BURST_LIMIT)) state_next = IDLE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_reg      <= IDLE;
         grant_reg      <= 3'd0;
         last_grant_reg <= 3'(NUM_REQ - 1);
         beat_cnt_reg   <= 8'd0;
         wrreq_reg      <= 1'b0;
         data_reg       <= '0;
         ovf_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         beat_cnt_reg   <= beat_cnt_next;
         wrreq_reg      <= wrreq_next;
         data_reg       <= data_next;
         ovf_reg        <= ovf_reg | (wrreq_reg & user_flag_0);
      end
   end

   assign user_wrreq = wrreq_reg;
   assign user_data  = data_reg;
   assign grant_id   = grant_reg;
   assign busy       = (state_reg == XFER);
   assign ovf_err    = ovf_reg;

endmodule

// File: tb/tb_user_wr_arbiter.sv
// Directed bench for user_wr_arbiter: per-requester beat queues feed the DUT, accepted beats
// go to a scoreboard that is drained against the FIFO write port one cycle later.
module tb_user_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 32;

   logic             clk_clk = 1'b0;
   logic             reset_reset_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    req_ready;
   logic             user_wrreq;
   logic [DW-1:0]    user_data;
   logic             user_flag_0;
   logic             user_flag_1;
   logic [2:0]       grant_id;
   logic             busy;
   logic             ovf_err;

   always #5 clk_clk = ~clk_clk;

   user_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8)) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .user_wrreq   (user_wrreq),
      .user_data    (user_data),
      .user_flag_0  (user_flag_0),
      .user_flag_1  (user_flag_1),
      .grant_id     (grant_id),
      .busy         (busy),
      .ovf_err      (ovf_err)
   );

   int checks   = 0;
   int failures = 0;

   logic [32:0] src_q [NR][$];   // {last, data}
   logic [34:0] sb [$];          // {requester, data}
   logic [2:0]  grant_log [$];
   int          burst_log [$];

   int phase_acc = 0, gap_cnt = 0, wr_cnt = 0;
   int bp_left = 0, rst_left = 0, rst_at = 0;
   bit ovf_inject = 0, rst_edge = 0, acc_prev = 0, exp_ovf = 0;
   bit prev_busy = 0, prev_flag1 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]           = (src_q[i].size() > 0);
         req_data[i*DW +: DW]   = (src_q[i].size() > 0) ? src_q[i][0][31:0] : 32'h0;
         req_last[i]            = (src_q[i].size() > 0) ? src_q[i][0][32] : 1'b0;
      end
      user_flag_1 = 1'b0;
      if (bp_left > 0 && phase_acc >= 2) begin
         user_flag_1 = 1'b1;
         bp_left--;
      end
      user_flag_0 = 1'b0;
      if (ovf_inject && phase_acc >= 1) begin
         user_flag_0 = 1'b1;
         ovf_inject  = 1'b0;
      end
      if (rst_at > 0 && phase_acc >= rst_at) begin
         rst_left = 3;
         rst_at   = 0;
      end
      if (rst_left > 0) begin
         reset_reset_n = 1'b0;
         rst_left--;
      end else begin
         reset_reset_n = 1'b1;
      end
   endtask

   task automatic monitor();
      bit          acc_now;
      bit          exp_wr;
      logic [3:0]  exp_ready;
      logic [34:0] ent;
      acc_now = 1'b0;
      if (rst_edge) begin
         sb.delete();
         exp_ovf = 1'b0;
         exp_wr  = 1'b0;
         chk("rst_wrreq", 64'(user_wrreq), 64'(0));
         chk("rst_data",  64'(user_data),  64'(0));
         chk("rst_grant", 64'(grant_id),   64'(0));
         chk("rst_busy",  64'(busy),       64'(0));
         chk("rst_ovf",   64'(ovf_err),    64'(0));
         chk("rst_ready", 64'(req_ready),  64'(0));
      end else begin
         exp_wr = acc_prev;
         chk("wrreq", 64'(user_wrreq), 64'(exp_wr));
         if (user_wrreq) begin
            wr_cnt++;
            if (sb.size() > 0) begin
               ent = sb.pop_front();
               chk("wr_data",  64'(user_data), 64'(ent[31:0]));
               chk("wr_grant", 64'(grant_id),  64'(ent[34:32]));
            end else begin
               chk("sb_size", 64'(sb.size()), 64'(1));
            end
         end
         chk("ovf_err", 64'(ovf_err), 64'(exp_ovf));
         exp_ready = (busy && !user_flag_1 && reset_reset_n) ? (4'b0001 << grant_id) : 4'b0000;
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         if (prev_flag1) chk("bp_no_wr", 64'(user_wrreq), 64'(0));
      end
      exp_ovf = exp_ovf | (exp_wr & user_flag_0);

      if (busy && !prev_busy) begin
         grant_log.push_back(grant_id);
         burst_log.push_back(0);
      end
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            sb.push_back({3'(i), src_q[i][0][31:0]});
            void'(src_q[i].pop_front());
            acc_now = 1'b1;
            phase_acc++;
            if (burst_log.size() > 0)
               burst_log[burst_log.size()-1] = burst_log[burst_log.size()-1] + 1;
         end
      end
      if (!busy && (req_valid != '0) && reset_reset_n) gap_cnt++;
      acc_prev   = acc_now;
      prev_busy  = busy;
      prev_flag1 = user_flag_1;
   endtask

   task automatic step();
      @(posedge clk_clk);
      #1;
      rst_edge = !reset_reset_n;
      drive();
      @(negedge clk_clk);
      monitor();
   endtask

   task automatic run_phase(input string name, input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      phase_acc = 0;
      gap_cnt   = 0;
      wr_cnt    = 0;
      grant_log.delete();
      burst_log.delete();
      while (!done && n < budget) begin
         step();
         n++;
         done = (sb.size() == 0) && !busy && !acc_prev && (bp_left == 0) &&
                (rst_left == 0) && (rst_at == 0) && !ovf_inject;
         for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) done = 1'b0;
      end
      chk({name, "_done"}, 64'(done), 64'(1));
   endtask

   task automatic check_logs(input string name, input int eg[$], input int eb[$]);
      chk({name, "_ngrants"}, 64'(grant_log.size()), 64'(eg.size()));
      for (int k = 0; k < eg.size(); k++) begin
         if (k < grant_log.size()) chk({name, "_grant"}, 64'(grant_log[k]), 64'(eg[k]));
         if (k < burst_log.size()) chk({name, "_burst"}, 64'(burst_log[k]), 64'(eb[k]));
      end
   endtask

   initial begin
      int eg[$];
      int eb[$];
      req_valid = '0; req_data = '0; req_last = '0;
      user_flag_0 = 1'b0; user_flag_1 = 1'b0;
      rst_left = 3;
      drive();
      repeat (3) step();

      // All four requesters with 2-beat packets; requester 0 has a second packet queued.
      for (int i = 0; i < NR; i++) begin
         src_q[i].push_back({1'b0, 32'(32'hF000_0000 + i*256 + 0)});
         src_q[i].push_back({1'b1, 32'(32'hF000_0000 + i*256 + 1)});
      end
      src_q[0].push_back({1'b0, 32'hF000_0002});
      src_q[0].push_back({1'b1, 32'hF000_0003});
      run_phase("fair", 200);
      eg = {0, 1, 2, 3, 0}; eb = {2, 2, 2, 2, 2};
      check_logs("fair", eg, eb);
      chk("fair_gaps", 64'(gap_cnt), 64'(5));
      chk("fair_wr",   64'(wr_cnt),  64'(10));

      // Requester 2: 20 beats without last, capped at 8 per grant.
      for (int k = 0; k < 20; k++) src_q[2].push_back({1'b0, 32'(32'hC0DE_0000 + k)});
      run_phase("cap", 300);
      eg = {2, 2, 2}; eb = {8, 8, 4};
      check_logs("cap", eg, eb);
      chk("cap_gaps", 64'(gap_cnt), 64'(3));
      chk("cap_wr",   64'(wr_cnt),  64'(20));

      // Requester 3: almost-full asserted for 5 cycles after the second beat.
      for (int k = 0; k < 6; k++) src_q[3].push_back({(k == 5), 32'(32'h3300_0000 + k)});
      bp_left = 5;
      run_phase("bp", 200);
      eg = {3}; eb = {6};
      check_logs("bp", eg, eb);
      chk("bp_wr", 64'(wr_cnt), 64'(6));

      // Requester 1 data path; write word must hold afterwards.
      src_q[1].push_back({1'b0, 32'hDEAD_BEEF});
      src_q[1].push_back({1'b1, 32'h0000_0001});
      run_phase("dpath", 100);
      eg = {1}; eb = {2};
      check_logs("dpath", eg, eb);
      step();
      step();
      chk("data_hold",  64'(user_data), 64'(32'h0000_0001));
      chk("grant_hold", 64'(grant_id),  64'(1));

      // FIFO full coincident with the first write pulse.
      for (int k = 0; k < 3; k++) src_q[0].push_back({(k == 2), 32'(32'h0A00_0000 + k)});
      ovf_inject = 1'b1;
      run_phase("ovf", 100);
      eg = {0}; eb = {3};
      check_logs("ovf", eg, eb);
      step();
      chk("ovf_sticky", 64'(ovf_err), 64'(1));

      // Reset for 3 cycles mid-burst of requester 1; requester 0 must win right after.
      for (int k = 0; k < 10; k++) src_q[1].push_back({(k == 9), 32'(32'h1100_0000 + k)});
      src_q[0].push_back({1'b0, 32'h0B00_0000});
      src_q[0].push_back({1'b1, 32'h0B00_0001});
      src_q[2].push_back({1'b0, 32'h2200_0000});
      src_q[2].push_back({1'b1, 32'h2200_0001});
      rst_at = 3;
      run_phase("rst", 300);
      eg = {1, 0, 1, 2}; eb = {3, 2, 7, 2};
      check_logs("rst", eg, eb);
      chk("ovf_after_rst", 64'(ovf_err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
